riscv_operand_stage: RTL and testbench
======================================

Name: riscv_operand_stage

Overview:
- Decode→execute pipeline stage; sits directly upstream of the register file's read ports.
- Drives the regfile read addresses and collects the asynchronous read data.
- Resolves RAW hazards by forwarding from the EX/MEM/WB stages, and stalls on load-use.
- Registers the resolved operands into the execute stage over a valid/ready handshake.

Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle passed through to execute.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk_in  input  1  sole clock; everything is on the rising edge.
- rst_n_in  input  1  reset; asynchronous, active-low.
- flush_in  input  1  kill the held output and any accept this cycle (branch redirect).
- in_valid_in  input  1  decode presents an instruction.
- in_ready_out  output  1  stage accepts this cycle.
- in_pc_in  input  32  instruction PC.
- in_rs1_in, in_rs2_in  input  5  source register indices.
- in_use_rs1_in, in_use_rs2_in  input  1  source is actually read.
- in_rd_in  input  5  destination index.
- in_imm_in  input  32  immediate.
- in_ctrl_in  input  CTRL_W  control bundle.
- ra_out, rb_out  output  5  regfile read addresses; combinational, equal to in_rs1_in and in_rs2_in.
- rd1_in, rd2_in  input  32  regfile read data; asynchronous read, pre-write value.
- ex_valid_in, ex_is_load_in  input  1  state of the execute stage.
- ex_rd_in  input  5  execute destination index.
- ex_result_in  input  32  execute ALU result.
- mem_valid_in  input  1  memory stage valid.
- mem_rd_in  input  5  memory destination index.
- mem_result_in  input  32  memory result.
- wb_valid_in  input  1  writeback valid; same-cycle regfile write.
- wb_rd_in  input  5  writeback destination index.
- wb_data_in  input  32  writeback data.
- out_valid_out  output  1  operands valid for execute.
- out_ready_in  input  1  execute accepts.
- out_pc_out  output  32  registered PC.
- out_a_out, out_b_out  output  32  resolved operands.
- out_imm_out  output  32  registered immediate.
- out_rd_out  output  5  registered destination.
- out_ctrl_out  output  CTRL_W  registered control bundle.
- stall_cnt_out  output  CNT_W  stall-cycle counter.

Behaviour:
- Reset (rst_n_in=0, asynchronous): out_valid_out=0; all out_* data=0; stall_cnt_out=0. Reset asserted mid-stall or mid-hold discards everything.
- Hazard match on source s: use_s && rs_s!=0 && stage_valid && stage_rd==rs_s.
- Load-use hazard: a match against EX with ex_is_load_in=1.
- Forward select per operand, highest priority first:
  - EX match, non-load: ex_result_in.
  - MEM match: mem_result_in.
  - WB match: wb_data_in. Needed because the regfile write lands at the same edge.
  - Otherwise the regfile read data.
- rs=0 always yields 32'h0, with no forwarding from any stage.
- in_ready_out = !flush_in && !hazard && (!out_valid_out || out_ready_in). Combinational.
- Accept (in_valid_in && in_ready_out): at the next edge, out_* take the resolved values and out_valid_out=1. Latency is 1 cycle.
- Drain without accept (out_ready_in=1): out_valid_out←0.
- Hold (out_valid_out && !out_ready_in): every out_* is stable, bit for bit.
- flush_in=1: out_valid_out←0 at the next edge and nothing is accepted. Flush beats accept, hold and drain.
- stall_cnt_out increments when in_valid_in && hazard && !flush_in; it saturates at all-ones.

Optional Feature:
- Macro: RISCV_OPFWD_EN.
- Defined: forwarding as above; the only hazard is load-use.
- Undefined:
  - No forward muxes; operands come from rd1_in/rd2_in or 0.
  - Hazard = any valid EX, MEM or WB match, including WB.
  - The stage stalls until the producer retires past WB.

Decomposition:
- Shared package riscv_pkg holds:
  - CTRL_W default.
  - fwd_sel_t enum {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
  - REG_ZERO constant 5'd0.
- Sub-module riscv_fwd_mux, instantiated once per operand:
  - Inputs: rs, use, stage buses.
  - Outputs: fwd_sel_t, data, hazard bit.

Test Plan:
- Reset, then accept rs1=5 and rs2=6 with rd1=32'h11 and rd2=32'h22, no stage matches → one cycle later out_valid=1, a=32'h11, b=32'h22.
- EX writes rd=5 with 32'hAA, MEM writes rd=5 with 32'hBB, WB writes rd=5 with 32'hCC; accept rs1=5 → a=32'hAA. Remove EX → a=32'hBB. Remove MEM → a=32'hCC.
- ex_is_load=1 and ex_rd=7, present rs2=7 with use_rs2=1:
  - in_ready=0 for as long as the load stays in EX; stall_cnt increments each cycle.
  - Next cycle MEM matches with 32'h5 → accept, b=32'h5.
- rs1=0, with EX/MEM/WB all writing rd=0 with 32'hFFFF_FFFF → a=0 and no stall.
- out_ready=0 for 3 cycles while wb_data changes → out_* unchanged and in_ready=0. Then out_ready=1 with a new input → next item appears one cycle later.
- flush_in=1 while holding and while in_valid=1 → out_valid=0 next cycle and the input is not consumed. Async rst_n_in=0 mid-cycle → out_valid drops immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the decode->execute operand stage
//
// Contents:
//   CTRL_W_DEFAULT  default width of the opaque decoded-control bundle
//   REG_ZERO        architectural zero register index
//   fwd_sel_t       operand source select (regfile, WB, MEM, EX)
//   src_hit()       RAW match of one source operand against one pipeline stage
//
// Optional feature macro used by files importing this package: RISCV_OPFWD_EN

package riscv_pkg;

  localparam int CTRL_W_DEFAULT = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_t;

  // A source only collides with a producer when it is really read, is not x0,
  // and the producer stage holds a live instruction writing that register.
  function automatic logic src_hit(
    input logic       use_src,
    input logic [4:0] rs,
    input logic       stage_valid,
    input logic [4:0] stage_rd
  );
    return use_src && (rs != REG_ZERO) && stage_valid && (stage_rd == rs);
  endfunction

endpackage

// File: rtl/riscv_fwd_mux.sv
// rtl/riscv_fwd_mux.sv - per-operand hazard detection and forwarding select
//
// Feature macro: RISCV_OPFWD_EN
//   defined   : forward from EX (non-load), MEM, WB; only a load in EX is a hazard
//   undefined : no forwarding; any live EX/MEM/WB producer of the source is a hazard
//
// Ports:
//   use_src, rs                     source operand being resolved
//   rf_data                         regfile asynchronous read data (pre-write value)
//   ex_valid/ex_is_load/ex_rd/ex_result   execute stage state
//   mem_valid/mem_rd/mem_result           memory stage state
//   wb_valid/wb_rd/wb_data                writeback stage state
//   sel                             chosen operand source
//   data                            resolved operand value (x0 always reads 0)
//   hazard                          operand cannot be resolved this cycle

module riscv_fwd_mux
  import riscv_pkg::*;
(
  input  logic        use_src,
  input  logic [4:0]  rs,
  input  logic [31:0] rf_data,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output fwd_sel_t    sel,
  output logic [31:0] data,
  output logic        hazard
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign ex_hit  = src_hit(use_src, rs, ex_valid, ex_rd);
  assign mem_hit = src_hit(use_src, rs, mem_valid, mem_rd);
  assign wb_hit  = src_hit(use_src, rs, wb_valid, wb_rd);

`ifdef RISCV_OPFWD_EN

  // Youngest producer wins. A load in EX has no data yet, so it stalls the
  // operand; the select then falls back to RF, which is never consumed.
  always_comb begin
    sel    = FWD_RF;
    hazard = 1'b0;
    if (ex_hit) begin
      if (ex_is_load) begin
        hazard = 1'b1;
      end else begin
        sel = FWD_EX;
      end
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    data = 32'h0;
    case (sel)
      FWD_EX:  data = ex_result;
      FWD_MEM: data = mem_result;
      FWD_WB:  data = wb_data;
      default: data = (rs == REG_ZERO) ? 32'h0 : rf_data;
    endcase
  end

`else

  // Without forwarding the stage waits until the producer has left WB; the
  // WB match counts too because the regfile read still shows the old value.
  always_comb begin
    sel    = FWD_RF;
    hazard = ex_hit | mem_hit | wb_hit;
  end

  always_comb begin
    data = (rs == REG_ZERO) ? 32'h0 : rf_data;
  end

  logic unused_fwd;
  assign unused_fwd = ^{ex_is_load, ex_result, mem_result, wb_data};

`endif

endmodule

// File: rtl/riscv_operand_stage.sv
// rtl/riscv_operand_stage.sv - operand read/forward stage between decode and execute
//
// Feature macro: RISCV_OPFWD_EN (enables EX/MEM/WB forwarding; default is stall-only)
//
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   flush_in                    kill held output and any accept this cycle
//   in_valid_in/in_ready_out    decode handshake
//   in_pc_in, in_rs1_in, in_rs2_in, in_use_rs1_in, in_use_rs2_in,
//   in_rd_in, in_imm_in, in_ctrl_in            decoded instruction fields
//   ra_out, rb_out              regfile read addresses (combinational)
//   rd1_in, rd2_in              regfile read data
//   ex_*, mem_*, wb_*           downstream stage state for hazards/forwarding
//   out_valid_out/out_ready_in  execute handshake
//   out_pc_out, out_a_out, out_b_out, out_imm_out, out_rd_out, out_ctrl_out
//                               registered operands and pass-through fields
//   stall_cnt_out               saturating count of hazard-stalled cycles

module riscv_operand_stage
  import riscv_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              flush_in,
  input  logic              in_valid_in,
  output logic              in_ready_out,
  input  logic [31:0]       in_pc_in,
  input  logic [4:0]        in_rs1_in,
  input  logic [4:0]        in_rs2_in,
  input  logic              in_use_rs1_in,
  input  logic              in_use_rs2_in,
  input  logic [4:0]        in_rd_in,
  input  logic [31:0]       in_imm_in,
  input  logic [CTRL_W-1:0] in_ctrl_in,
  output logic [4:0]        ra_out,
  output logic [4:0]        rb_out,
  input  logic [31:0]       rd1_in,
  input  logic [31:0]       rd2_in,
  input  logic              ex_valid_in,
  input  logic              ex_is_load_in,
  input  logic [4:0]        ex_rd_in,
  input  logic [31:0]       ex_result_in,
  input  logic              mem_valid_in,
  input  logic [4:0]        mem_rd_in,
  input  logic [31:0]       mem_result_in,
  input  logic              wb_valid_in,
  input  logic [4:0]        wb_rd_in,
  input  logic [31:0]       wb_data_in,
  output logic              out_valid_out,
  input  logic              out_ready_in,
  output logic [31:0]       out_pc_out,
  output logic [31:0]       out_a_out,
  output logic [31:0]       out_b_out,
  output logic [31:0]       out_imm_out,
  output logic [4:0]        out_rd_out,
  output logic [CTRL_W-1:0] out_ctrl_out,
  output logic [CNT_W-1:0]  stall_cnt_out
);

  logic [31:0] a_data;
  logic [31:0] b_data;
  logic        a_hazard;
  logic        b_hazard;
  fwd_sel_t    a_sel;
  fwd_sel_t    b_sel;
  logic        hazard;
  logic        accept;

  assign ra_out = in_rs1_in;
  assign rb_out = in_rs2_in;

  riscv_fwd_mux u_fwd_a (
    .use_src    (in_use_rs1_in),
    .rs         (in_rs1_in),
    .rf_data    (rd1_in),
    .ex_valid   (ex_valid_in),
    .ex_is_load (ex_is_load_in),
    .ex_rd      (ex_rd_in),
    .ex_result  (ex_result_in),
    .mem_valid  (mem_valid_in),
    .mem_rd     (mem_rd_in),
    .mem_result (mem_result_in),
    .wb_valid   (wb_valid_in),
    .wb_rd      (wb_rd_in),
    .wb_data    (wb_data_in),
    .sel        (a_sel),
    .data       (a_data),
    .hazard     (a_hazard)
  );

  riscv_fwd_mux u_fwd_b (
    .use_src    (in_use_rs2_in),
    .rs         (in_rs2_in),
    .rf_data    (rd2_in),
    .ex_valid   (ex_valid_in),
    .ex_is_load (ex_is_load_in),
    .ex_rd      (ex_rd_in),
    .ex_result  (ex_result_in),
    .mem_valid  (mem_valid_in),
    .mem_rd     (mem_rd_in),
    .mem_result (mem_result_in),
    .wb_valid   (wb_valid_in),
    .wb_rd      (wb_rd_in),
    .wb_data    (wb_data_in),
    .sel        (b_sel),
    .data       (b_data),
    .hazard     (b_hazard)
  );

  // The select is only observable through the data mux.
  logic unused_sel;
  assign unused_sel = ^{a_sel, b_sel};

  assign hazard       = a_hazard | b_hazard;
  assign in_ready_out = !flush_in && !hazard && (!out_valid_out || out_ready_in);
  assign accept       = in_valid_in && in_ready_out;

  // Payload registers load only on accept, so a held item stays bit-stable
  // and a flushed or drained slot keeps its last payload with valid low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_valid_out <= 1'b0;
      out_pc_out    <= 32'h0;
      out_a_out     <= 32'h0;
      out_b_out     <= 32'h0;
      out_imm_out   <= 32'h0;
      out_rd_out    <= 5'd0;
      out_ctrl_out  <= '0;
    end else if (flush_in) begin
      out_valid_out <= 1'b0;
    end else if (accept) begin
      out_valid_out <= 1'b1;
      out_pc_out    <= in_pc_in;
      out_a_out     <= a_data;
      out_b_out     <= b_data;
      out_imm_out   <= in_imm_in;
      out_rd_out    <= in_rd_in;
      out_ctrl_out  <= in_ctrl_in;
    end else if (out_ready_in) begin
      out_valid_out <= 1'b0;
    end
  end

  // Counts cycles lost to hazards only; back-pressure from execute is not a stall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_cnt_out <= '0;
    end else if (in_valid_in && hazard && !flush_in && !(&stall_cnt_out)) begin
      stall_cnt_out <= stall_cnt_out + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_riscv_operand_stage.sv
// tb/tb_riscv_operand_stage.sv - self-checking bench for riscv_operand_stage

module tb_riscv_operand_stage;

  localparam int CW = 16;
  localparam int NW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_pc = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic          in_use_rs1 = 1'b0;
  logic          in_use_rs2 = 1'b0;
  logic [4:0]    in_rd = '0;
  logic [31:0]   in_imm = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [4:0]    ra;
  logic [4:0]    rb;
  logic [31:0]   rd1 = '0;
  logic [31:0]   rd2 = '0;
  logic          ex_valid = 1'b0;
  logic          ex_is_load = 1'b0;
  logic [4:0]    ex_rd = '0;
  logic [31:0]   ex_result = '0;
  logic          mem_valid = 1'b0;
  logic [4:0]    mem_rd = '0;
  logic [31:0]   mem_result = '0;
  logic          wb_valid = 1'b0;
  logic [4:0]    wb_rd = '0;
  logic [31:0]   wb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_pc;
  logic [31:0]   out_a;
  logic [31:0]   out_b;
  logic [31:0]   out_imm;
  logic [4:0]    out_rd;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  always #5 clk = ~clk;

  riscv_operand_stage #(.CTRL_W(CW), .CNT_W(NW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
    .in_valid_in(in_valid), .in_ready_out(in_ready), .in_pc_in(in_pc),
    .in_rs1_in(in_rs1), .in_rs2_in(in_rs2),
    .in_use_rs1_in(in_use_rs1), .in_use_rs2_in(in_use_rs2),
    .in_rd_in(in_rd), .in_imm_in(in_imm), .in_ctrl_in(in_ctrl),
    .ra_out(ra), .rb_out(rb), .rd1_in(rd1), .rd2_in(rd2),
    .ex_valid_in(ex_valid), .ex_is_load_in(ex_is_load), .ex_rd_in(ex_rd),
    .ex_result_in(ex_result), .mem_valid_in(mem_valid), .mem_rd_in(mem_rd),
    .mem_result_in(mem_result), .wb_valid_in(wb_valid), .wb_rd_in(wb_rd),
    .wb_data_in(wb_data), .out_valid_out(out_valid), .out_ready_in(out_ready),
    .out_pc_out(out_pc), .out_a_out(out_a), .out_b_out(out_b),
    .out_imm_out(out_imm), .out_rd_out(out_rd), .out_ctrl_out(out_ctrl),
    .stall_cnt_out(stall_cnt)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what execute must see, derived from the stage's rules.
  logic          m_valid = 1'b0;
  logic [31:0]   m_pc = '0, m_a = '0, m_b = '0, m_imm = '0;
  logic [4:0]    m_rd = '0;
  logic [CW-1:0] m_ctrl = '0;
  int            m_cnt = 0;

  // Returns {stall, value} for one source operand.
  function automatic logic [32:0] resolve(input logic u, input logic [4:0] rs, input logic [31:0] rf);
    bit live_ex, live_mem, live_wb;
    if (!u || rs == 5'd0) return {1'b0, (rs == 5'd0) ? 32'h0 : rf};
    live_ex  = ex_valid  && ex_rd  == rs;
    live_mem = mem_valid && mem_rd == rs;
    live_wb  = wb_valid  && wb_rd  == rs;
`ifdef RISCV_OPFWD_EN
    if (live_ex && ex_is_load) return {1'b1, 32'h0};
    if (live_ex)  return {1'b0, ex_result};
    if (live_mem) return {1'b0, mem_result};
    if (live_wb)  return {1'b0, wb_data};
`else
    if (live_ex || live_mem || live_wb) return {1'b1, 32'h0};
`endif
    return {1'b0, rf};
  endfunction

  function automatic bit model_ready();
    logic [32:0] a, b;
    a = resolve(in_use_rs1, in_rs1, rd1);
    b = resolve(in_use_rs2, in_rs2, rd2);
    return !flush && !a[32] && !b[32] && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      logic [32:0] a, b;
      bit rdy;
      a   = resolve(in_use_rs1, in_rs1, rd1);
      b   = resolve(in_use_rs2, in_rs2, rd2);
      rdy = model_ready();
      if (in_valid && (a[32] || b[32]) && !flush && m_cnt < (1 << NW) - 1) m_cnt = m_cnt + 1;
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin
        m_valid = 1'b1; m_pc = in_pc; m_a = a[31:0]; m_b = b[31:0];
        m_imm = in_imm; m_rd = in_rd; m_ctrl = in_ctrl;
      end else if (out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    m_valid = 1'b0; m_pc = '0; m_a = '0; m_b = '0; m_imm = '0; m_rd = '0; m_ctrl = '0; m_cnt = 0;
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("ready", in_ready, model_ready());
      chk("ra", ra, in_rs1);
      chk("rb", rb, in_rs2);
      chk("out_valid", out_valid, m_valid);
      chk("out_pc", out_pc, m_pc);
      chk("out_a", out_a, m_a);
      chk("out_b", out_b, m_b);
      chk("out_imm", out_imm, m_imm);
      chk("out_rd", out_rd, m_rd);
      chk("out_ctrl", out_ctrl, m_ctrl);
      chk("stall_cnt", stall_cnt, m_cnt[NW-1:0]);
    end
  end

  task automatic clear_stages();
    ex_valid = 0; ex_is_load = 0; mem_valid = 0; wb_valid = 0;
  endtask

  task automatic edge_then_drive();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd6;
      default: return 5'd7;
    endcase
  endfunction

  logic [31:0] d2_a [4];
  bit          d2_rdy [4];
  logic [31:0] hold_pc;
  int          d3_cnt;

  initial begin
`ifdef RISCV_OPFWD_EN
    d2_a = '{32'hAA, 32'hBB, 32'hCC, 32'h33};
    d2_rdy = '{1'b1, 1'b1, 1'b1, 1'b1};
    d3_cnt = 3;
`else
    d2_a = '{32'h0, 32'h0, 32'h0, 32'h33};
    d2_rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
    d3_cnt = 4;
`endif

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cnt", stall_cnt, '0);
    chk("rst_a", out_a, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Plain accept from the regfile.
    in_valid = 1; in_pc = 32'h1000; in_rs1 = 5; in_rs2 = 6; in_use_rs1 = 1; in_use_rs2 = 1;
    in_rd = 9; in_imm = 32'h77; in_ctrl = 16'hBEEF; rd1 = 32'h11; rd2 = 32'h22;
    #1 chk("d1_ready", in_ready, 1'b1);
    edge_then_drive();
    chk("d1_valid", out_valid, 1'b1);
    chk("d1_a", out_a, 32'h11);
    chk("d1_b", out_b, 32'h22);
    in_valid = 0;
    edge_then_drive();

    // Forward priority EX > MEM > WB > regfile.
    ex_rd = 5; ex_result = 32'hAA; mem_rd = 5; mem_result = 32'hBB; wb_rd = 5; wb_data = 32'hCC;
    in_valid = 1; in_rs1 = 5; in_use_rs1 = 1; in_rs2 = 0; in_use_rs2 = 0; rd1 = 32'h33;
    for (int k = 0; k < 4; k++) begin
      ex_valid = (k < 1); mem_valid = (k < 2); wb_valid = (k < 3);
      #1 chk("d2_ready", in_ready, d2_rdy[k]);
      edge_then_drive();
      if (d2_rdy[k]) chk("d2_a", out_a, d2_a[k]);
      else chk("d2_stalled", out_valid, 1'b0);
    end
    in_valid = 0; clear_stages();

    // Reset discards everything, then load-use.
    rst_n = 0;
    edge_then_drive();
    rst_n = 1;
    ex_valid = 1; ex_is_load = 1; ex_rd = 7;
    in_valid = 1; in_rs1 = 0; in_use_rs1 = 0; in_rs2 = 7; in_use_rs2 = 1; rd2 = 32'h9;
    for (int i = 1; i <= 3; i++) begin
      #1 chk("d3_ready", in_ready, 1'b0);
      edge_then_drive();
      chk("d3_cnt", stall_cnt, NW'(i));
    end
    ex_valid = 0; ex_is_load = 0; mem_valid = 1; mem_rd = 7; mem_result = 32'h5;
`ifndef RISCV_OPFWD_EN
    #1 chk("d3_mem_stall", in_ready, 1'b0);
    edge_then_drive();
    mem_valid = 0;
    #1 chk("d3_ready_rf", in_ready, 1'b1);
    edge_then_drive();
    chk("d3_b", out_b, 32'h9);
`else
    #1 chk("d3_ready_fwd", in_ready, 1'b1);
    edge_then_drive();
    chk("d3_b", out_b, 32'h5);
`endif
    chk("d3_cnt_final", stall_cnt, NW'(d3_cnt));

    // x0 is never forwarded and never stalls.
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; ex_result = 32'hFFFF_FFFF;
    mem_valid = 1; mem_rd = 0; mem_result = 32'hFFFF_FFFF;
    wb_valid = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
    in_rs1 = 0; in_use_rs1 = 1; in_rs2 = 0; in_use_rs2 = 1; rd1 = 32'hFFFF_FFFF; rd2 = 32'hFFFF_FFFF;
    #1 chk("d4_ready", in_ready, 1'b1);
    edge_then_drive();
    chk("d4_a", out_a, 32'h0);
    chk("d4_b", out_b, 32'h0);
    chk("d4_cnt", stall_cnt, NW'(d3_cnt));
    clear_stages();

    // Hold: payload stable under back-pressure.
    in_pc = 32'h100; in_rs1 = 3; in_use_rs1 = 1; rd1 = 32'h123;
    edge_then_drive();
    out_ready = 0; in_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      wb_data = $urandom; rd1 = $urandom;
      #1 chk("d5_ready", in_ready, 1'b0);
      edge_then_drive();
      chk("d5_pc", out_pc, 32'h100);
      chk("d5_a", out_a, 32'h123);
    end
    out_ready = 1; in_pc = 32'h200; rd1 = 32'h456;
    #1 chk("d5_ready_release", in_ready, 1'b1);
    edge_then_drive();
    chk("d5_next_pc", out_pc, 32'h200);
    chk("d5_next_a", out_a, 32'h456);

    // Flush while holding with an input pending.
    out_ready = 0; flush = 1; in_pc = 32'h300;
    #1 chk("d6_ready", in_ready, 1'b0);
    edge_then_drive();
    chk("d6_valid", out_valid, 1'b0);
    flush = 0; in_valid = 0; out_ready = 1;
    edge_then_drive();
    chk("d6_not_consumed", out_valid, 1'b0);
    in_valid = 1; in_pc = 32'h400;
    edge_then_drive();
    chk("d6_accept", out_valid, 1'b1);
    in_valid = 0;
    #2 rst_n = 0;
    #1 chk("d6_async_valid", out_valid, 1'b0);
    chk("d6_async_pc", out_pc, 32'h0);
    edge_then_drive();
    rst_n = 1;

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      edge_then_drive();
      flush      = ($urandom_range(0, 15) == 0);
      in_valid   = $urandom_range(0, 1);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_pc      = $urandom; in_imm = $urandom; in_ctrl = CW'($urandom);
      in_rs1     = pick_reg(); in_rs2 = pick_reg(); in_rd = pick_reg();
      in_use_rs1 = $urandom_range(0, 1); in_use_rs2 = $urandom_range(0, 1);
      rd1        = $urandom; rd2 = $urandom;
      ex_valid   = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
      ex_rd      = pick_reg(); ex_result = $urandom;
      mem_valid  = $urandom_range(0, 1); mem_rd = pick_reg(); mem_result = $urandom;
      wb_valid   = $urandom_range(0, 1); wb_rd = pick_reg(); wb_data = $urandom;
    end
    edge_then_drive();
    chk("cnt_saturated", stall_cnt, {NW{1'b1}});

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
